// File: rtl/uart_pkg.sv
// uart_pkg: shared UART sequencer constants, state encoding and the default message text.
package uart_pkg;
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] WRITE   = 3'd2;
  localparam logic [2:0] WAIT_LO = 3'd3;
  localparam logic [2:0] WAIT_HI = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam int MSG_CHARS = 16;
  localparam logic [8*MSG_CHARS-1:0] MSG_TEXT = {"HELLO UART 460", CR, LF};
  // First character sits in the most significant byte; out-of-range entries read as space.
  function automatic logic [7:0] msg_char(input int i);
    return (i >= 0 && i < MSG_CHARS) ? MSG_TEXT[8*(MSG_CHARS-1-i) +: 8] : 8'h20;
  endfunction
endpackage

// File: rtl/msg_rom.sv
// msg_rom: synchronous-read message ROM built from the package text.
module msg_rom
  import uart_pkg::*;
#(
  parameter int MSG_LEN = 16,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 4
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  addr,
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] rom [MSG_LEN];
  for (genvar i = 0; i < MSG_LEN; i++) begin : g_rom
    assign rom[i] = DATA_W'(msg_char(i));
  end
  always_ff @(posedge clk) data <= rom[addr];
endmodule

// File: rtl/tx_msg_sequencer.sv
// tx_msg_sequencer: streams the ROM message into the UART transmit engine once per start pulse.
module tx_msg_sequencer
  import uart_pkg::*;
#(
  parameter int MSG_LEN = 16,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              tx_rdy,
  output logic              tx_wr,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(MSG_LEN - 1);
  logic [2:0]        state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [DATA_W-1:0] rom_q;
  always_comb begin
    state_d = state;
    idx_d   = idx;
    case (state)
      IDLE: begin
        idx_d   = '0;
        state_d = start ? LOAD : IDLE;
      end
      LOAD:    state_d = WRITE;
      WRITE:   state_d = tx_rdy ? WAIT_LO : WRITE;
      WAIT_LO: state_d = tx_rdy ? WAIT_LO : WAIT_HI;
      WAIT_HI: begin
        state_d = !tx_rdy ? WAIT_HI : (idx == LAST) ? DONE : LOAD;
        idx_d   = (tx_rdy && idx != LAST) ? idx + 1'b1 : idx;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // ROM is addressed with the next index so its registered output matches idx during LOAD.
  msg_rom #(.MSG_LEN(MSG_LEN), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_rom (
    .clk  (clk),
    .addr (idx_d),
    .data (rom_q)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      tx_wr   <= 1'b0;
      tx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      tx_wr   <= state == WRITE && tx_rdy;
      tx_data <= state == LOAD ? rom_q : tx_data;
      busy    <= state_d != IDLE;
      done    <= state_d == DONE;
    end
  end
endmodule

// File: tb/tb_tx_msg_sequencer.sv
// tb_tx_msg_sequencer: vector table, random runs and corner sequences against a message-level model.
module tb_tx_msg_sequencer;
  localparam int MSG_LEN = 16;
  logic clk = 0, rst = 0, start = 0, hold_low = 0, eng_rdy = 1;
  logic tx_rdy, tx_wr, busy, done;
  logic [7:0] tx_data;
  int checks = 0, failures = 0;
  int drop_dly = 1, low_len = 10;
  logic [7:0] got[$];
  string msg = "HELLO UART 460\r\n";

  assign tx_rdy = eng_rdy & ~hold_low;
  always #5 clk = ~clk;

  tx_msg_sequencer #(.MSG_LEN(MSG_LEN), .DATA_W(8), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_rdy(tx_rdy),
    .tx_wr(tx_wr), .tx_data(tx_data), .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Transmit engine model plus handshake scoreboard: every strobe is captured in got.
  initial begin
    int cd, cl;
    bit seen_low;
    cd = 0; cl = 0; seen_low = 1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        eng_rdy = 1; cd = 0; cl = 0; seen_low = 1;
      end else begin
        if (tx_wr) begin
          checks += 2;
          if (!tx_rdy) begin failures++; $display("FAIL wr_while_not_rdy actual=0 required=1"); end
          if (!seen_low) begin failures++; $display("FAIL wr_without_rdy_low actual=0 required=1"); end
          got.push_back(tx_data);
          seen_low = 0;
        end else if (!tx_rdy) seen_low = 1;
        if (cl > 0) begin
          cl--;
          if (cl == 0) eng_rdy = 1;
        end else if (cd > 0) begin
          cd--;
          if (cd == 0) begin eng_rdy = 0; cl = low_len; end
        end
        if (tx_wr) cd = drop_dly;
      end
    end
  end

  // Entered at the first negedge after a one-cycle start pulse (that is cycle 1).
  task automatic collect(input string nm, input bit spam, input int exp_first, input int post);
    int c, first;
    bit seen, busy_ok, idle_ok;
    c = 1; first = -1; seen = 0; busy_ok = 1; idle_ok = 1;
    forever begin
      if (tx_wr && first < 0) first = c;
      if (!busy) busy_ok = 0;
      if (done) begin seen = 1; break; end
      if (c >= 3000) break;
      start = spam && (c == 4 || c == 39 || c == 40);
      @(negedge clk);
      c++;
    end
    chk({nm, "_done"}, 32'(seen), 1);
    chk({nm, "_busy_held"}, 32'(busy_ok), 1);
    if (exp_first > 0) chk({nm, "_latency"}, first, exp_first);
    start = (post == 1);
    @(negedge clk);
    start = 0;
    chk({nm, "_busy_fall"}, {30'h0, busy, done}, 0);
    chk({nm, "_count"}, got.size(), MSG_LEN);
    for (int i = 0; i < MSG_LEN; i++)
      chk($sformatf("%s_byte%0d", nm, i), (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF, {24'h0, msg[i]});
    if (post == 2) begin
      start = 1;
      @(negedge clk);
      start = 0;
    end else begin
      repeat (5) begin
        @(negedge clk);
        if (busy || done) idle_ok = 0;
      end
      chk({nm, "_stays_idle"}, 32'(idle_ok), 1);
    end
  endtask

  task automatic run_msg(input string nm, input int dly, input int lo, input bit spam, input int post);
    drop_dly = dly;
    low_len = lo;
    got.delete();
    start = 1;
    @(negedge clk);
    start = 0;
    collect(nm, spam, 3, post);
  endtask

  typedef struct {
    string nm;
    int    dly;
    int    lo;
    bit    spam;
    int    post;
  } vec_t;

  initial begin
    vec_t vt[5];
    int c;
    bit nowr;
    vt[0] = '{"basic", 1, 10, 1'b0, 0};
    vt[1] = '{"fast", 2, 1, 1'b0, 0};
    vt[2] = '{"spam", 1, 10, 1'b1, 0};
    vt[3] = '{"start_on_done", 1, 3, 1'b0, 1};
    vt[4] = '{"start_after_done", 2, 5, 1'b0, 2};

    repeat (3) @(negedge clk);
    chk("reset_outs", {29'h0, tx_wr, busy, done}, 0);
    chk("reset_data", {24'h0, tx_data}, 0);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("post_reset_outs", {29'h0, tx_wr, busy, done}, 0);
    chk("post_reset_data", {24'h0, tx_data}, 0);

    foreach (vt[k]) begin
      run_msg(vt[k].nm, vt[k].dly, vt[k].lo, vt[k].spam, vt[k].post);
      if (vt[k].post == 2) begin
        got.delete();
        collect({vt[k].nm, "_second"}, 1'b0, 3, 0);
      end
    end

    for (int r = 0; r < 6; r++)
      run_msg($sformatf("rnd%0d", r), $urandom_range(1, 2), $urandom_range(1, 10), 1'($urandom_range(0, 1)), 0);

    // Ready held low before the first byte.
    drop_dly = 1; low_len = 4;
    hold_low = 1;
    got.delete();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    nowr = 1;
    repeat (100) begin
      if (tx_wr || !busy) nowr = 0;
      @(negedge clk);
    end
    chk("stall_no_wr", 32'(nowr), 1);
    hold_low = 0;
    @(negedge clk);
    chk("stall_first_wr", 32'(tx_wr), 1);
    chk("stall_first_byte", {24'h0, tx_data}, 32'h48);
    collect("stall", 1'b0, -1, 0);

    // Asynchronous reset mid-message, then a fresh message from the start.
    drop_dly = 1; low_len = 10;
    got.delete();
    start = 1;
    @(negedge clk);
    start = 0;
    c = 0;
    while (got.size() < 5 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("abort_reached5", got.size(), 5);
    repeat (3) @(negedge clk);
    chk("abort_pre_busy", 32'(busy), 1);
    #2 rst = 0;
    #1 chk("abort_outs", {29'h0, tx_wr, busy, done}, 0);
    chk("abort_data", {24'h0, tx_data}, 0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_held", {29'h0, tx_wr, busy, done}, 0);
    rst = 1;
    repeat (2) @(negedge clk);
    run_msg("after_abort", 1, 10, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
